// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and the arbiter path FSM state types.
package axi_lite_pkg;

  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {WIdle, WAddr, WResp} wr_state_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} rd_state_e;

endpackage

// File: rtl/axi_lite_rr_arb2.sv
// Two-requester arbiter: combinational pick plus a "who won last" pointer that
// moves only when the caller accepts the pick.
module axi_lite_rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_last_m1;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (!RR_EN || r_last_m1) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_last_m1 <= 1'b1;
    end else if (i_advance) begin
      r_last_m1 <= o_grant[1];
    end
  end

endmodule

// File: rtl/axi_lite_2to1_arbiter.sv
// AXI4-Lite 2->1 arbiter: independent write and read paths, one outstanding
// transaction each, grant held until the response handshake.
module axi_lite_2to1_arbiter
  import axi_lite_pkg::*;
#(
  parameter bit          RR_EN  = 1'b1,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_W-1:0]     i_m0_awaddr,
  input  logic [2:0]            i_m0_awprot,
  input  logic                  i_m0_awvalid,
  output logic                  o_m0_awready,
  input  logic [AXI_DATA_W-1:0] i_m0_wdata,
  input  logic [AXI_STRB_W-1:0] i_m0_wstrb,
  input  logic                  i_m0_wvalid,
  output logic                  o_m0_wready,
  output logic [1:0]            o_m0_bresp,
  output logic                  o_m0_bvalid,
  input  logic                  i_m0_bready,
  input  logic [ADDR_W-1:0]     i_m0_araddr,
  input  logic [2:0]            i_m0_arprot,
  input  logic                  i_m0_arvalid,
  output logic                  o_m0_arready,
  output logic [AXI_DATA_W-1:0] o_m0_rdata,
  output logic [1:0]            o_m0_rresp,
  output logic                  o_m0_rvalid,
  input  logic                  i_m0_rready,
  input  logic [ADDR_W-1:0]     i_m1_awaddr,
  input  logic [2:0]            i_m1_awprot,
  input  logic                  i_m1_awvalid,
  output logic                  o_m1_awready,
  input  logic [AXI_DATA_W-1:0] i_m1_wdata,
  input  logic [AXI_STRB_W-1:0] i_m1_wstrb,
  input  logic                  i_m1_wvalid,
  output logic                  o_m1_wready,
  output logic [1:0]            o_m1_bresp,
  output logic                  o_m1_bvalid,
  input  logic                  i_m1_bready,
  input  logic [ADDR_W-1:0]     i_m1_araddr,
  input  logic [2:0]            i_m1_arprot,
  input  logic                  i_m1_arvalid,
  output logic                  o_m1_arready,
  output logic [AXI_DATA_W-1:0] o_m1_rdata,
  output logic [1:0]            o_m1_rresp,
  output logic                  o_m1_rvalid,
  input  logic                  i_m1_rready,
  output logic [ADDR_W-1:0]     o_s_awaddr,
  output logic [2:0]            o_s_awprot,
  output logic                  o_s_awvalid,
  input  logic                  i_s_awready,
  output logic [AXI_DATA_W-1:0] o_s_wdata,
  output logic [AXI_STRB_W-1:0] o_s_wstrb,
  output logic                  o_s_wvalid,
  input  logic                  i_s_wready,
  input  logic [1:0]            i_s_bresp,
  input  logic                  i_s_bvalid,
  output logic                  o_s_bready,
  output logic [ADDR_W-1:0]     o_s_araddr,
  output logic [2:0]            o_s_arprot,
  output logic                  o_s_arvalid,
  input  logic                  i_s_arready,
  input  logic [AXI_DATA_W-1:0] i_s_rdata,
  input  logic [1:0]            i_s_rresp,
  input  logic                  i_s_rvalid,
  output logic                  o_s_rready,
  output logic [1:0]            o_wr_grant,
  output logic [1:0]            o_rd_grant
);

  wr_state_e  r_wst;
  rd_state_e  r_rst;
  logic [1:0] r_wr_grant, r_rd_grant, w_wr_pick, w_rd_pick;
  logic       r_aw_done, r_w_done;
  logic       w_wr_start, w_rd_start, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic       w_aw_rdy, w_w_rdy, w_b_vld, w_ar_rdy, w_r_vld;

  axi_lite_rr_arb2 #(.RR_EN(RR_EN)) u_wr_arb (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_req    ({i_m1_awvalid, i_m0_awvalid}),
    .i_advance(w_wr_start),
    .o_grant  (w_wr_pick)
  );

  axi_lite_rr_arb2 #(.RR_EN(RR_EN)) u_rd_arb (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_req    ({i_m1_arvalid, i_m0_arvalid}),
    .i_advance(w_rd_start),
    .o_grant  (w_rd_pick)
  );

  assign w_wr_start = (r_wst == WIdle) && (i_m0_awvalid || i_m1_awvalid);
  assign w_rd_start = (r_rst == RIdle) && (i_m0_arvalid || i_m1_arvalid);

  // Payloads follow the grant; valids and readies are additionally gated by state and reset.
  assign o_s_awaddr  = r_wr_grant[1] ? i_m1_awaddr : i_m0_awaddr;
  assign o_s_awprot  = r_wr_grant[1] ? i_m1_awprot : i_m0_awprot;
  assign o_s_wdata   = r_wr_grant[1] ? i_m1_wdata  : i_m0_wdata;
  assign o_s_wstrb   = r_wr_grant[1] ? i_m1_wstrb  : i_m0_wstrb;
  assign o_s_araddr  = r_rd_grant[1] ? i_m1_araddr : i_m0_araddr;
  assign o_s_arprot  = r_rd_grant[1] ? i_m1_arprot : i_m0_arprot;

  assign o_s_awvalid = aresetn && (r_wst == WAddr) && !r_aw_done &&
                       (r_wr_grant[1] ? i_m1_awvalid : i_m0_awvalid);
  assign o_s_wvalid  = aresetn && (r_wst == WAddr) && !r_w_done &&
                       (r_wr_grant[1] ? i_m1_wvalid : i_m0_wvalid);
  assign o_s_bready  = aresetn && (r_wst == WResp) &&
                       (r_wr_grant[1] ? i_m1_bready : i_m0_bready);
  assign o_s_arvalid = aresetn && (r_rst == RAddr) &&
                       (r_rd_grant[1] ? i_m1_arvalid : i_m0_arvalid);
  assign o_s_rready  = aresetn && (r_rst == RData) &&
                       (r_rd_grant[1] ? i_m1_rready : i_m0_rready);

  assign w_aw_hs = o_s_awvalid && i_s_awready;
  assign w_w_hs  = o_s_wvalid && i_s_wready;
  assign w_b_hs  = o_s_bready && i_s_bvalid;
  assign w_ar_hs = o_s_arvalid && i_s_arready;
  assign w_r_hs  = o_s_rready && i_s_rvalid;

  // Master-facing handshakes depend only on S inputs and registered state.
  assign w_aw_rdy = aresetn && (r_wst == WAddr) && !r_aw_done && i_s_awready;
  assign w_w_rdy  = aresetn && (r_wst == WAddr) && !r_w_done && i_s_wready;
  assign w_b_vld  = aresetn && (r_wst == WResp) && i_s_bvalid;
  assign w_ar_rdy = aresetn && (r_rst == RAddr) && i_s_arready;
  assign w_r_vld  = aresetn && (r_rst == RData) && i_s_rvalid;

  assign o_m0_awready = w_aw_rdy && r_wr_grant[0];
  assign o_m1_awready = w_aw_rdy && r_wr_grant[1];
  assign o_m0_wready  = w_w_rdy && r_wr_grant[0];
  assign o_m1_wready  = w_w_rdy && r_wr_grant[1];
  assign o_m0_bvalid  = w_b_vld && r_wr_grant[0];
  assign o_m1_bvalid  = w_b_vld && r_wr_grant[1];
  assign o_m0_arready = w_ar_rdy && r_rd_grant[0];
  assign o_m1_arready = w_ar_rdy && r_rd_grant[1];
  assign o_m0_rvalid  = w_r_vld && r_rd_grant[0];
  assign o_m1_rvalid  = w_r_vld && r_rd_grant[1];
  assign o_m0_bresp   = i_s_bresp;
  assign o_m1_bresp   = i_s_bresp;
  assign o_m0_rdata   = i_s_rdata;
  assign o_m1_rdata   = i_s_rdata;
  assign o_m0_rresp   = i_s_rresp;
  assign o_m1_rresp   = i_s_rresp;
  assign o_wr_grant   = r_wr_grant;
  assign o_rd_grant   = r_rd_grant;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wst      <= WIdle;
      r_wr_grant <= 2'b00;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      unique case (r_wst)
        WIdle: if (w_wr_start) begin
          r_wr_grant <= w_wr_pick;
          r_wst      <= WAddr;
        end
        WAddr: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) r_wst <= WResp;
        end
        WResp: if (w_b_hs) begin
          r_wst      <= WIdle;
          r_wr_grant <= 2'b00;
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
        end
        default: r_wst <= WIdle;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rst      <= RIdle;
      r_rd_grant <= 2'b00;
    end else begin
      unique case (r_rst)
        RIdle: if (w_rd_start) begin
          r_rd_grant <= w_rd_pick;
          r_rst      <= RAddr;
        end
        RAddr: if (w_ar_hs) r_rst <= RData;
        RData: if (w_r_hs) begin
          r_rst      <= RIdle;
          r_rd_grant <= 2'b00;
        end
        default: r_rst <= RIdle;
      endcase
    end
  end

endmodule
